// File: rtl/xab_pkg.sv
// Shared state encodings for the scan arbiter controller and its sequence detector.
package xab_pkg;

  // Controller phases: wait for a request, scan a frame, present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  // Sequence detector states.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

endpackage

// File: rtl/xab_detector.sv
// Four-state Mealy sequence detector; y/z are combinational from state and x.
module xab_detector
  import xab_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic y,
  output logic z
);

  det_state_t state;
  det_state_t state_nxt;

  // State register; clear takes priority over enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Mealy outputs.
  always_comb begin
    state_nxt = state;
    y         = 1'b0;
    z         = 1'b0;
    case (state)
      S0: y = 1'b0;
      S1: y = 1'b0;
      S2: z = ~x;
      S3: y = x;
      default: y = 1'b0;
    endcase
    if (clr) begin
      state_nxt = S0;
    end else if (en) begin
      case (state)
        S0:      state_nxt = x ? S1 : S3;
        S1:      state_nxt = S2;
        S2:      state_nxt = x ? S3 : S0;
        S3:      state_nxt = x ? S3 : S1;
        default: state_nxt = S0;
      endcase
    end
  end

endmodule

// File: rtl/xab_scan_arbiter.sv
// Two-requester round-robin arbiter that scans each accepted frame MSB-first
// through a sequence detector and reports how often y and z fired.
module xab_scan_arbiter
  import xab_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [CW-1:0]    res_ycnt,
  output logic [CW-1:0]    res_zcnt
);

  localparam int unsigned BW = $clog2(WIDTH + 1);

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    ycnt;
  logic [CW-1:0]    zcnt;
  logic             pri;
  logic             active_id;
  logic             grant_id;
  logic             accept;
  logic             shifting;
  logic             last_bit;
  logic             det_y;
  logic             det_z;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grant selection and handshake; pri holds the preferred requester on a tie.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    shifting   = 1'b0;
    last_bit   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_id   = (req0_valid && req1_valid) ? pri : req1_valid;
    case (state)
      IDLE: begin
        if (rst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        shifting = 1'b1;
        if (bit_cnt == '0) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame shift register, bit counter, running counts and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      ycnt      <= '0;
      zcnt      <= '0;
      pri       <= 1'b0;
      active_id <= 1'b0;
    end else if (accept) begin
      shreg     <= grant_id ? req1_data : req0_data;
      bit_cnt   <= BW'(WIDTH - 1);
      ycnt      <= '0;
      zcnt      <= '0;
      pri       <= ~grant_id;
      active_id <= grant_id;
    end else if (shifting) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt - BW'(1);
      ycnt    <= ycnt + CW'(det_y);
      zcnt    <= zcnt + CW'(det_z);
    end
  end

  // Result registers: loaded with the final counts on the last scanned bit, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_ycnt  <= '0;
      res_zcnt  <= '0;
    end else begin
      res_valid <= last_bit;
      if (last_bit) begin
        res_id   <= active_id;
        res_ycnt <= ycnt + CW'(det_y);
        res_zcnt <= zcnt + CW'(det_z);
      end
    end
  end

  xab_detector u_detector (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (shifting),
    .x   (shreg[WIDTH-1]),
    .y   (det_y),
    .z   (det_z)
  );

endmodule
